lsu_apb_master: RTL
===================

Name: lsu_apb_master

Overview:
- Single-outstanding APB-style requester between the pipeline LSU and the memory-mapped banks: slot 0 = data memory, slot 1 = output peripheral bank, slot 2 = input peripheral bank.
- Accepts one load/store request, decodes the region and checks alignment/funct, then runs a SETUP/ACCESS transfer on the selected bank.
- Returns read data or an error response; bounded by a timeout on missing pready.

Parameters:
- ADDR_W, 12, LSU byte-address width; region = addr[ADDR_W-1:ADDR_W-2].
- NUM_SLV, 3, number of APB slots; region code N selects slot N; codes >= NUM_SLV are unmapped.
- TIMEOUT, 15, maximum ACCESS cycles without pready before an error response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  LSU request valid.
- req_ready_o  out  1  master idle; a request is accepted when valid & ready.
- req_addr_i  in  ADDR_W  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  32  store data.
- req_funct_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- rsp_err_o  out  1  error qualifier, valid with rsp_valid_o.
- psel_o  out  NUM_SLV  one-hot slot select.
- penable_o  out  1  ACCESS phase.
- pwrite_o  out  1  captured req_we.
- paddr_o  out  ADDR_W-4  word index = captured addr[ADDR_W-3:2].
- pwdata_o  out  32  captured store data.
- pfunct_code_o  out  3  captured funct.
- prdata_i  in  NUM_SLV x 32  per-slot read data.
- pready_i  in  NUM_SLV  per-slot ready.

Behaviour:
- Reset:
  - state = IDLE; all registered outputs 0.
  - req_ready_o = (state == IDLE), so it is 1 once reset is released.
  - Reset mid-transfer drops psel/penable immediately; no response is issued for the aborted request.
- Request capture: on valid & ready, capture addr, we, wdata and funct; later changes on req_* are ignored until the next accept.
- Decode, on the accepted request; any failure gives an error and no transfer:
  - Unmapped region.
  - funct 011, 110 or 111.
  - Store with funct 100 or 101.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
- FSM states IDLE, SETUP, ACCESS, RESP.
  - IDLE: on accept, go to SETUP if decode is OK, else to RESP with err = 1.
  - SETUP: psel_o[slot] = 1, penable_o = 0, for exactly one cycle; then ACCESS.
  - ACCESS: psel_o[slot] = 1, penable_o = 1.
    - On pready_i[slot] = 1: capture prdata_i[slot] (loads only), err = 0, go to RESP.
    - Timeout counter clears on entry to ACCESS and increments each ACCESS cycle without pready. When it reaches TIMEOUT-1 with no pready, go to RESP with err = 1 and rdata = 0.
    - pready on non-selected slots is ignored.
  - RESP: rsp_valid_o = 1 for exactly one cycle, psel/penable = 0; then IDLE. req_ready_o = 0 in this state.
- Latency, with accept at edge N:
  - SETUP occupies cycle N+1.
  - ACCESS begins at N+2.
  - Zero-wait pready gives rsp_valid_o in cycle N+3.
  - Decode error gives rsp_valid_o in cycle N+1.
- Throughput: back-to-back requests are accepted no earlier than the cycle after RESP.
- All outputs are registered or decoded from state; no combinational path from pready_i or prdata_i to the outputs.
- pwrite/paddr/pwdata/pfunct hold their values from SETUP through ACCESS.

Decomposition:
- Package lsu_apb_pkg:
  - state enum;
  - FUNCT_* localparams;
  - region codes (REG_DMEM = 0, REG_OPERI = 1, REG_IPERI = 2).
- Sub-module lsu_apb_decode: combinational slot one-hot, map check and alignment/funct check, producing slot_oh and dec_err.

Test Plan:
- Load word addr 0x804, funct 010, slot 2 pready = 1 with prdata 0xDEADBEEF:
  - psel_o = 3'b100, paddr_o = 0x01;
  - rsp_valid_o at N+3 with rdata 0xDEADBEEF, err = 0.
- Store byte addr 0x410, wdata 0x000000A5, funct 000, slot 1 pready after 3 wait cycles:
  - pwrite_o = 1 and pwdata_o = 0xA5 held through all wait cycles;
  - rsp at N+6, rdata 0, err 0.
- Load addr 0xC00 (unmapped):
  - no psel asserted;
  - rsp_valid_o at N+1, err = 1.
- Misaligned lh at 0x003 and sw with funct 100 → each gives err = 1 at N+1 with zero APB activity.
- Slot 0 never asserts pready:
  - penable_o high for exactly 15 cycles;
  - rsp err = 1, rdata 0, then req_ready_o returns to 1.
- rst_ni pulsed low during ACCESS:
  - psel/penable drop asynchronously, no rsp_valid_o;
  - after release, a new load completes normally.

Source files
------------

// File: rtl/lsu_apb_pkg.sv
// Shared types and codes for the LSU-to-APB requester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // LSU access-size/extension codes; everything else is reserved.
  localparam logic [2:0] FUNCT_B  = 3'b000;
  localparam logic [2:0] FUNCT_H  = 3'b001;
  localparam logic [2:0] FUNCT_W  = 3'b010;
  localparam logic [2:0] FUNCT_BU = 3'b100;
  localparam logic [2:0] FUNCT_HU = 3'b101;

  // Region code (top two address bits) equals the APB slot index.
  localparam logic [1:0] REG_DMEM  = 2'd0;
  localparam logic [1:0] REG_OPERI = 2'd1;
  localparam logic [1:0] REG_IPERI = 2'd2;

endpackage

// File: rtl/lsu_apb_master_if.sv
// LSU request/response channel plus the APB-style bank bus.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o gates request acceptance; banks stall with pready_i.
// master modport = requester view, slave modport = LSU/bank environment view.
interface lsu_apb_master_if #(
  parameter int ADDR_W  = 12,
  parameter int NUM_SLV = 3
);
  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [ADDR_W-1:0]           req_addr_i;
  logic                        req_we_i;
  logic [31:0]                 req_wdata_i;
  logic [2:0]                  req_funct_i;
  logic                        rsp_valid_o;
  logic [31:0]                 rsp_rdata_o;
  logic                        rsp_err_o;
  logic [NUM_SLV-1:0]          psel_o;
  logic                        penable_o;
  logic                        pwrite_o;
  logic [ADDR_W-5:0]           paddr_o;
  logic [31:0]                 pwdata_o;
  logic [2:0]                  pfunct_code_o;
  logic [NUM_SLV-1:0][31:0]    prdata_i;
  logic [NUM_SLV-1:0]          pready_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_funct_i,
           prdata_i, pready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pfunct_code_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_funct_i,
           prdata_i, pready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pfunct_code_o
  );
endinterface

// File: rtl/lsu_apb_decode.sv
// Region-to-slot decode plus funct/alignment legality check for one request.
// Latency: combinational.
// Backpressure: none; evaluated only when the top accepts a request.
// Ports: region_i/addr_lo_i/we_i/funct_i in; slot_oh_o one-hot slot, dec_err_o reject.
module lsu_apb_decode
  import lsu_apb_pkg::*;
#(
  parameter int NUM_SLV = 3
) (
  input  logic [1:0]         region_i,
  input  logic [1:0]         addr_lo_i,
  input  logic               we_i,
  input  logic [2:0]         funct_i,
  output logic [NUM_SLV-1:0] slot_oh_o,
  output logic               dec_err_o
);

  logic mapped;
  logic op_bad;

  always_comb begin
    mapped    = int'(region_i) < NUM_SLV;
    slot_oh_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slot_oh_o[i] = mapped && (int'(region_i) == i);
    end

    // Unsigned-extending loads have no store counterpart.
    op_bad = 1'b1;
    case (funct_i)
      FUNCT_B:  op_bad = 1'b0;
      FUNCT_H:  op_bad = addr_lo_i[0];
      FUNCT_W:  op_bad = |addr_lo_i;
      FUNCT_BU: op_bad = we_i;
      FUNCT_HU: op_bad = we_i | addr_lo_i[0];
      default:  op_bad = 1'b1;
    endcase

    dec_err_o = !mapped || op_bad;
  end

endmodule

// File: rtl/lsu_apb_master.sv
// Single-outstanding LSU-to-APB requester: decode, SETUP/ACCESS transfer, one-cycle response.
// Latency: accept->rsp_valid 3 cycles at zero wait, 1 cycle on decode error, 2+TIMEOUT on timeout.
// Backpressure: req_ready_o only in IDLE; banks stall via pready_i, bounded by TIMEOUT ACCESS cycles.
// Ports: clk_i, rst_ni (async active-low), bus (master modport: LSU req/rsp + APB slots).
module lsu_apb_master
  import lsu_apb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int NUM_SLV = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lsu_apb_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-5:0]   paddr_q;
  logic [31:0]         pwdata_q;
  logic [2:0]          pfunct_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_SLV-1:0]  slot_oh;
  logic                dec_err;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

  lsu_apb_decode #(.NUM_SLV(NUM_SLV)) u_decode (
    .region_i  (bus.req_addr_i[ADDR_W-1 -: 2]),
    .addr_lo_i (bus.req_addr_i[1:0]),
    .we_i      (bus.req_we_i),
    .funct_i   (bus.req_funct_i),
    .slot_oh_o (slot_oh),
    .dec_err_o (dec_err)
  );

  // psel_q is one-hot, so an OR-mux picks the active slot; other slots are masked off.
  always_comb begin
    sel_ready = |(bus.pready_i & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | bus.prdata_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pfunct_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            pwrite_q <= bus.req_we_i;
            paddr_q  <= bus.req_addr_i[ADDR_W-3:2];
            pwdata_q <= bus.req_wdata_i;
            pfunct_q <= bus.req_funct_i;
            if (dec_err) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= S_SETUP;
              psel_q  <= slot_oh;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            state_q     <= S_RESP;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? 32'h0 : sel_rdata;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Last permitted ACCESS cycle passed with no pready: give up.
            state_q     <= S_RESP;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = (state_q == S_IDLE);
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pfunct_code_o = pfunct_q;

endmodule
